// File: rtl/button_conditioner.sv
// button_conditioner
//   Front-end input stage for the step sequencer. The six raw active-low
//   buttons (pad directions on bits 3:0, A on bit 4, B on bit 5) are
//   synchronised, debounced on a slow tick and turned into one-cycle
//   press/release events, with optional auto-repeat per button.
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_btn_n[5:0] raw buttons, active low, asynchronous to i_clk
//   o_level      debounced state, 1 = held
//   o_press      one-cycle pulse per debounced press and per auto-repeat
//   o_release    one-cycle pulse per debounced release
//   o_any_press  OR of o_press
//
// The spec's names press/release/level are carried with the i_/o_ prefix;
// a bare "release" is a reserved word in SystemVerilog.

// Per-button debounce counter and IDLE/HOLD/RPT event FSM.
module button_lane #(
    parameter int DB_TICKS  = 20,
    parameter int RPT_DELAY = 400,
    parameter int RPT_RATE  = 100,
    parameter bit RPT_EN    = 1'b1,
    parameter int CW        = 9
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_tick,
    input  logic i_s,
    output logic o_level,
    output logic o_press,
    output logic o_release
);
    localparam logic [CW-1:0] DB_LAST   = CW'(DB_TICKS - 1);
    localparam logic [CW-1:0] DLY_LAST  = CW'(RPT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST = CW'(RPT_RATE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_RPT} state_t;

    logic          r_level;
    logic [CW-1:0] r_dcnt;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_rcnt,  w_rcnt_nxt;
    logic          r_press, w_press_nxt;
    logic          r_release, w_release_nxt;

    // The debounced level toggles on this tick; the FSM reacts to the same
    // condition so press/release land on the same edge as the level change.
    logic w_db_hit, w_rise, w_fall;
    assign w_db_hit = i_tick && (i_s != r_level) && (r_dcnt == DB_LAST);
    assign w_rise   = w_db_hit && !r_level;
    assign w_fall   = w_db_hit &&  r_level;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level <= 1'b0;
            r_dcnt  <= '0;
        end else if (i_s == r_level) begin
            r_dcnt  <= '0;
        end else if (i_tick) begin
            if (r_dcnt == DB_LAST) begin
                r_level <= ~r_level;
                r_dcnt  <= '0;
            end else begin
                r_dcnt  <= r_dcnt + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_rcnt    <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rcnt_nxt    = r_rcnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_HOLD;
                    w_press_nxt = 1'b1;
                    w_rcnt_nxt  = '0;
                end
            end
            ST_HOLD: begin
                // A fall wins over a repeat due in the same cycle.
                if (w_fall) begin
                    w_state_nxt   = ST_IDLE;
                    w_release_nxt = 1'b1;
                end else if (i_tick) begin
                    if (RPT_EN) begin
                        if (r_rcnt == DLY_LAST) begin
                            w_state_nxt = ST_RPT;
                            w_press_nxt = 1'b1;
                            w_rcnt_nxt  = '0;
                        end else begin
                            w_rcnt_nxt  = r_rcnt + CW'(1);
                        end
                    end else if (r_rcnt != DLY_LAST) begin
                        // Non-repeating: count saturates, never wraps.
                        w_rcnt_nxt = r_rcnt + CW'(1);
                    end
                end
            end
            ST_RPT: begin
                if (w_fall) begin
                    w_state_nxt   = ST_IDLE;
                    w_release_nxt = 1'b1;
                end else if (i_tick) begin
                    if (r_rcnt == RATE_LAST) begin
                        w_press_nxt = 1'b1;
                        w_rcnt_nxt  = '0;
                    end else begin
                        w_rcnt_nxt  = r_rcnt + CW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_rcnt_nxt  = '0;
            end
        endcase
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
endmodule

module button_conditioner #(
    parameter int         TICK_DIV  = 27000,
    parameter int         DB_TICKS  = 20,
    parameter int         RPT_DELAY = 400,
    parameter int         RPT_RATE  = 100,
    parameter logic [5:0] RPT_MASK  = 6'b001111
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_btn_n,
    output logic [5:0] o_level,
    output logic [5:0] o_press,
    output logic [5:0] o_release,
    output logic       o_any_press
);
    localparam int NUM_BTN = 6;
    localparam int CMAX_A  = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int CMAX    = (CMAX_A > DB_TICKS) ? CMAX_A : DB_TICKS;
    localparam int CW      = $clog2(CMAX + 1);
    localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    // Synchroniser resets to all-ones (released) so reset cannot look like
    // a press.
    logic [NUM_BTN-1:0] r_sync1, r_sync2;
    logic [NUM_BTN-1:0] w_s;
    logic [TW-1:0]      r_tcnt;
    logic               w_tick;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
        end
    end
    assign w_s = ~r_sync2;

    always_ff @(posedge i_clk) begin
        if (i_rst)                   r_tcnt <= '0;
        else if (r_tcnt == TICK_LAST) r_tcnt <= '0;
        else                          r_tcnt <= r_tcnt + TW'(1);
    end
    assign w_tick = (r_tcnt == TICK_LAST);

    logic [NUM_BTN-1:0] w_level, w_press, w_release;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
        button_lane #(
            .DB_TICKS (DB_TICKS),
            .RPT_DELAY(RPT_DELAY),
            .RPT_RATE (RPT_RATE),
            .RPT_EN   (RPT_MASK[g]),
            .CW       (CW)
        ) u_lane (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_tick   (w_tick),
            .i_s      (w_s[g]),
            .o_level  (w_level[g]),
            .o_press  (w_press[g]),
            .o_release(w_release[g])
        );
    end

    assign o_level     = w_level;
    assign o_press     = w_press;
    assign o_release   = w_release;
    assign o_any_press = |w_press;
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end input stage for the step sequencer: synchronises the raw active-low push-buttons (four-way cursor pad, A, B), debounces each one, and converts presses into single-cycle event pulses with optional auto-repeat. The sequencer's cursor and cell-edit logic consumes `press` pulses instead of sampling raw pins on a slow counter bit. Holding a direction then steps the cursor smoothly.

## Interface
- `TICK_DIV`, 27000: clk cycles per internal tick (1 kHz at 27 MHz).
- `DB_TICKS`, 20: consecutive mismatching ticks required to change a debounced level.
- `RPT_DELAY`, 400: ticks from a press to the first auto-repeat.
- `RPT_RATE`, 100: ticks between later auto-repeats.
- `RPT_MASK`, 6'b001111: per-button auto-repeat enable. Bits 3:0 are the directions; bits 4 and 5 are A and B.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `btn_n` input 6: raw buttons, active-low, asynchronous. Bits 3:0 are the pad, bit 4 is A, bit 5 is B.
- `level` output 6: debounced state, 1 = held.
- `press` output 6: one-cycle pulse on each debounced press and on each auto-repeat.
- `release` output 6: one-cycle pulse on each debounced release.
- `any_press` output 1: OR of `press`.

## Operation
- **Synchroniser:** 2-flop synchroniser per bit, then invert: `s[i]` = 1 means pressed. Synchroniser flops reset to 1 (released) so that reset itself cannot produce a press.
- **Tick prescaler:**
  - `tcnt` counts 0..`TICK_DIV`-1, then wraps.
  - `tick` is high for the single cycle in which `tcnt`==`TICK_DIV`-1.
  - All debounce and repeat counters advance only on `tick`.
- **Debounce, per button:**
  - `dcnt` clears in any cycle where `s[i]`==`level[i]`.
  - On a tick with `s[i]`!=`level[i]`:
    - if `dcnt`==`DB_TICKS`-1: `level[i]` toggles and `dcnt` clears;
    - otherwise `dcnt` increments.
  - A bounce shorter than `DB_TICKS` ticks never changes `level`.
- **Event FSM, per button.** States are IDLE, HOLD and RPT.
  - **IDLE → HOLD:** on a `level` rise, `press` pulses and `rcnt` clears.
  - **HOLD:** on a tick, `rcnt` increments.
    - If `RPT_MASK[i]`=1 and `rcnt` reaches `RPT_DELAY`-1 on a tick: `press` pulses, `rcnt` clears, next state is RPT.
    - If `RPT_MASK[i]`=0: stay in HOLD, no further pulses.
  - **RPT:** on a tick with `rcnt`==`RPT_RATE`-1, `press` pulses and `rcnt` clears; otherwise `rcnt` increments on tick.
  - **HOLD/RPT → IDLE:** on a `level` fall, `release` pulses. No `press` is emitted in that cycle, even if a repeat was due.
- **Counter widths:** `rcnt` and `dcnt` are wide enough for the largest of `RPT_DELAY`, `RPT_RATE` and `DB_TICKS`; counters never wrap.
- **Independence:** buttons are fully independent. Simultaneous presses produce simultaneous pulses on the respective bits.

## Timing
- **Reset:** all outputs are 0. `tcnt`, `dcnt`, `rcnt` are 0; FSMs are in IDLE; synchroniser flops are 1.
- **Reset mid-operation:** reset aborts everything immediately, with no `release` pulse.
- **Press latency:** a clean press is seen in `s` 2 cycles after `btn_n` falls. `level` and `press` assert on the clk edge that ends the `DB_TICKS`-th mismatching tick. Worst case is (`DB_TICKS`)·`TICK_DIV`+2 cycles.
- **Alignment:** `press` and `level` change on the same edge; `release` and the `level` fall change on the same edge.
- **Pulse width:** every `press`/`release` pulse is exactly 1 cycle. A repeat pulse coincides with a tick cycle.
- **Auto-repeat spacing:** first repeat `RPT_DELAY` ticks after the initial press, then one every `RPT_RATE` ticks.
- **Non-repeating buttons:** a held button with `RPT_MASK`=0 produces exactly one `press` per debounced press.
- **Boundary cases:**
  - `btn_n` held low through reset: press is reported `DB_TICKS` ticks after `rst` deasserts.
  - Release and re-press within `DB_TICKS` ticks: invisible.

## Test plan
Bench parameters: `TICK_DIV`=4, `DB_TICKS`=3, `RPT_DELAY`=5, `RPT_RATE`=2.

1. **Reset:** hold `rst` 5 cycles with `btn_n`=6'h3F → all outputs 0. Pull `btn_n[0]` low 2 cycles before `rst` falls → `press[0]` pulses once, 3 ticks later, and never during reset.
2. **Bounce rejection:** toggle `btn_n[1]` low/high for 7 cycles (under 3 ticks) repeatedly → `level`, `press` and `release` stay 0.
3. **Clean press/release:** press bit 2 for 4 ticks then release → one `press[2]`, then `release[2]` 3 ticks after the release; each pulse lasts 1 cycle.
4. **Auto-repeat:** hold bit 3 for 15 ticks after the debounced press → `press[3]` at 0, +5, +7, +9, +11, +13 ticks. Release at +12 ticks with the repeat due on the release edge → `release` only.
5. **Non-repeating button:** hold bit 4 (A) for 20 ticks → exactly one `press[4]`.
6. **Simultaneous buttons and reset mid-hold:** press bits 0 and 5 together → same-cycle `press`, `any_press`=1. Assert `rst` during RPT → outputs 0 next cycle, no `release` pulse.
